// File: rtl/control_puerta_acceso_pkg.sv
// Shared constants for the door-access controller: one-hot state encoding
// and default timing/lockout parameters.
package control_puerta_acceso_pkg;

    localparam logic [3:0] REPOSO        = 4'b0001;
    localparam logic [3:0] ABIERTO       = 4'b0010;
    localparam logic [3:0] ALARMA_PUERTA = 4'b0100;
    localparam logic [3:0] BLOQUEADO     = 4'b1000;

    localparam int MAX_INTENTOS_DEF = 3;
    localparam int T_APERTURA_DEF   = 50;

endpackage

// File: rtl/control_puerta_acceso_detector_flanco.sv
// Rising-edge detector. The history register resets high so that a level
// already asserted when reset is released is not reported as an event.
module detector_flanco (
    input  logic CLK,
    input  logic RESET_N,
    input  logic entrada,
    output logic flanco
);

    logic prev;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev <= 1'b1;
        end else begin
            prev <= entrada;
        end
    end

    assign flanco = entrada & ~prev;

endmodule

// File: rtl/control_puerta_acceso.sv
// Door actuator / alarm controller fed by the PIN-entry FSM: counts failed
// attempts with admin-released lockout and times the door-open window.
module control_puerta_acceso
    import control_puerta_acceso_pkg::*;
#(
    parameter int MAX_INTENTOS = MAX_INTENTOS_DEF,
    parameter int T_APERTURA   = T_APERTURA_DEF,
    parameter int ANCHO_T      = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ACCESO_ACEPTADO,
    input  logic       ACCESO_DENEGADO,
    input  logic       PUERTA_CERRADA,
    input  logic       DESBLOQUEO_ADMIN,
    output logic       ABRIR_PUERTA,
    output logic       ALARMA,
    output logic       BLOQUEO,
    output logic [1:0] INTENTOS
);

    localparam logic [2:0]         MAX_INT3 = 3'(MAX_INTENTOS);
    localparam logic [1:0]         MAX_INT2 = 2'(MAX_INTENTOS);
    localparam logic [ANCHO_T-1:0] T_INI    = ANCHO_T'(T_APERTURA - 1);

    logic [3:0]         estado, estado_sig;
    logic [1:0]         intentos_sig;
    logic [ANCHO_T-1:0] timer, timer_sig;
    logic               abrir_sig, alarma_sig, bloqueo_sig;
    logic               ev_ok, ev_den;

    detector_flanco u_flanco_ok (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .entrada (ACCESO_ACEPTADO),
        .flanco  (ev_ok)
    );

    detector_flanco u_flanco_den (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .entrada (ACCESO_DENEGADO),
        .flanco  (ev_den)
    );

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            estado       <= REPOSO;
            INTENTOS     <= 2'd0;
            timer        <= '0;
            ABRIR_PUERTA <= 1'b0;
            ALARMA       <= 1'b0;
            BLOQUEO      <= 1'b0;
        end else begin
            estado       <= estado_sig;
            INTENTOS     <= intentos_sig;
            timer        <= timer_sig;
            ABRIR_PUERTA <= abrir_sig;
            ALARMA       <= alarma_sig;
            BLOQUEO      <= bloqueo_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        intentos_sig = INTENTOS;
        timer_sig    = timer;
        case (estado)
            REPOSO: begin
                // A simultaneous accept/deny is treated as a denial (fail-safe).
                if (ev_den) begin
                    if (({1'b0, INTENTOS} + 3'd1) >= MAX_INT3) begin
                        estado_sig   = BLOQUEADO;
                        intentos_sig = MAX_INT2;
                    end else begin
                        intentos_sig = INTENTOS + 2'd1;
                    end
                end else if (ev_ok) begin
                    estado_sig   = ABIERTO;
                    intentos_sig = 2'd0;
                    timer_sig    = T_INI;
                end
            end
            ABIERTO: begin
                if (timer == '0) begin
                    estado_sig = PUERTA_CERRADA ? REPOSO : ALARMA_PUERTA;
                end else begin
                    timer_sig = timer - 1'b1;
                end
            end
            ALARMA_PUERTA: begin
                if (PUERTA_CERRADA) begin
                    estado_sig = REPOSO;
                end
            end
            BLOQUEADO: begin
                if (DESBLOQUEO_ADMIN) begin
                    estado_sig   = REPOSO;
                    intentos_sig = 2'd0;
                end
            end
            default: begin
                estado_sig   = REPOSO;
                intentos_sig = 2'd0;
                timer_sig    = '0;
            end
        endcase
    end

    always_comb begin
        abrir_sig   = (estado_sig == ABIERTO);
        alarma_sig  = (estado_sig == ALARMA_PUERTA) || (estado_sig == BLOQUEADO);
        bloqueo_sig = (estado_sig == BLOQUEADO);
    end

endmodule

// File: tb/tb_control_puerta_acceso.sv
// Directed bench for control_puerta_acceso with default parameters
// (MAX_INTENTOS=3, T_APERTURA=50).
module tb_control_puerta_acceso;

    logic       CLK;
    logic       RESET_N;
    logic       ACCESO_ACEPTADO;
    logic       ACCESO_DENEGADO;
    logic       PUERTA_CERRADA;
    logic       DESBLOQUEO_ADMIN;
    logic       ABRIR_PUERTA;
    logic       ALARMA;
    logic       BLOQUEO;
    logic [1:0] INTENTOS;

    int checks = 0;
    int errors = 0;

    control_puerta_acceso dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .ACCESO_ACEPTADO  (ACCESO_ACEPTADO),
        .ACCESO_DENEGADO  (ACCESO_DENEGADO),
        .PUERTA_CERRADA   (PUERTA_CERRADA),
        .DESBLOQUEO_ADMIN (DESBLOQUEO_ADMIN),
        .ABRIR_PUERTA     (ABRIR_PUERTA),
        .ALARMA           (ALARMA),
        .BLOQUEO          (BLOQUEO),
        .INTENTOS         (INTENTOS)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_ok();
        ACCESO_ACEPTADO = 1'b1;
        tick();
        ACCESO_ACEPTADO = 1'b0;
    endtask

    task automatic pulse_den();
        ACCESO_DENEGADO = 1'b1;
        tick();
        ACCESO_DENEGADO = 1'b0;
        tick();
    endtask

    task automatic wait_door_closed_cmd(input string tag);
        int n;
        n = 0;
        while (ABRIR_PUERTA === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    initial begin
        int cnt;
        RESET_N          = 1'b1;
        ACCESO_ACEPTADO  = 1'b1;
        ACCESO_DENEGADO  = 1'b0;
        PUERTA_CERRADA   = 1'b1;
        DESBLOQUEO_ADMIN = 1'b0;
        #3 RESET_N = 1'b0;
        tick();
        tick();
        check("rst_abrir", ABRIR_PUERTA, 0);
        RESET_N = 1'b1;

        // Accept level already high at reset release: no event.
        tick();
        tick();
        check("rel_abrir", ABRIR_PUERTA, 0);
        check("rel_alarma", ALARMA, 0);
        check("rel_bloqueo", BLOQUEO, 0);
        check("rel_intentos", INTENTOS, 0);
        ACCESO_ACEPTADO = 1'b0;
        tick();

        // Single accept, door closed: open window of exactly 50 cycles.
        pulse_ok();
        check("open_first", ABRIR_PUERTA, 1);
        cnt = 1;
        while (ABRIR_PUERTA === 1'b1 && cnt < 100) begin
            tick();
            if (ABRIR_PUERTA === 1'b1) cnt++;
        end
        check("open_len", cnt, 50);
        check("open_end_alarma", ALARMA, 0);
        check("open_end_abrir", ABRIR_PUERTA, 0);

        // Three denials lock out; further accept ignored; admin releases.
        pulse_den();
        check("den1", INTENTOS, 1);
        check("den1_bloqueo", BLOQUEO, 0);
        pulse_den();
        check("den2", INTENTOS, 2);
        pulse_den();
        check("den3", INTENTOS, 3);
        check("lock_bloqueo", BLOQUEO, 1);
        check("lock_alarma", ALARMA, 1);
        pulse_ok();
        tick();
        check("lock_ok_ignored", ABRIR_PUERTA, 0);
        check("lock_still", BLOQUEO, 1);
        pulse_den();
        check("lock_sat", INTENTOS, 3);
        DESBLOQUEO_ADMIN = 1'b1;
        tick();
        DESBLOQUEO_ADMIN = 1'b0;
        check("admin_bloqueo", BLOQUEO, 0);
        check("admin_alarma", ALARMA, 0);
        check("admin_intentos", INTENTOS, 0);
        tick();

        // Two denials then accept clears the count.
        pulse_den();
        pulse_den();
        check("pre_ok_intentos", INTENTOS, 2);
        pulse_ok();
        check("ok_clears", INTENTOS, 0);
        check("ok_opens", ABRIR_PUERTA, 1);
        wait_door_closed_cmd("win2_bound");
        check("win2_alarma", ALARMA, 0);
        tick();
        pulse_den();
        check("after_ok_den", INTENTOS, 1);
        check("after_ok_nolock", BLOQUEO, 0);

        // Door left open at window expiry raises the alarm.
        PUERTA_CERRADA = 1'b0;
        pulse_ok();
        check("w3_open", ABRIR_PUERTA, 1);
        check("w3_intentos", INTENTOS, 0);
        wait_door_closed_cmd("win3_bound");
        check("w3_alarma", ALARMA, 1);
        check("w3_abrir", ABRIR_PUERTA, 0);
        pulse_den();
        tick();
        check("w3_den_ignored", INTENTOS, 0);
        check("w3_alarma_hold", ALARMA, 1);
        PUERTA_CERRADA = 1'b1;
        tick();
        check("w3_alarma_clr", ALARMA, 0);
        tick();

        // Reset mid-window: door drops without a clock edge.
        pulse_ok();
        for (int i = 1; i < 20; i++) tick();
        check("mid_open", ABRIR_PUERTA, 1);
        RESET_N = 1'b0;
        #1;
        check("async_rst_abrir", ABRIR_PUERTA, 0);
        check("async_rst_alarma", ALARMA, 0);
        tick();
        RESET_N = 1'b1;
        tick();

        // Simultaneous accept and deny counts as a denial.
        ACCESO_ACEPTADO = 1'b1;
        ACCESO_DENEGADO = 1'b1;
        tick();
        check("both_intentos", INTENTOS, 1);
        check("both_abrir", ABRIR_PUERTA, 0);
        check("both_bloqueo", BLOQUEO, 0);
        ACCESO_ACEPTADO = 1'b0;
        ACCESO_DENEGADO = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_puerta_acceso.md
Name: control_puerta_acceso

Overview:
- Downstream stage of the PIN-entry state machine. Consumes its ACCESO_ACEPTADO / ACCESO_DENEGADO level outputs and drives the door actuator and the alarm.
- Counts consecutive failed PIN attempts and locks the keypad path after MAX_INTENTOS failures. The lock is released only by an administrator.
- Times the door-open window and raises an alarm if the door is not closed when the window expires.

Parameters:
- MAX_INTENTOS, 3, consecutive denials that trigger lockout (legal range 1..3).
- T_APERTURA, 50, number of cycles ABRIR_PUERTA stays high (≥1).
- ANCHO_T, 8, width of the door timer; must satisfy 2^ANCHO_T > T_APERTURA.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ACCESO_ACEPTADO  input  1  level from the PIN FSM; a rising edge means PIN correct.
- ACCESO_DENEGADO  input  1  level from the PIN FSM; a rising edge means PIN wrong.
- PUERTA_CERRADA  input  1  door sensor, 1 = closed.
- DESBLOQUEO_ADMIN  input  1  admin release; sampled high for one or more cycles.
- ABRIR_PUERTA  output  1  door actuator enable.
- ALARMA  output  1  alarm enable.
- BLOQUEO  output  1  keypad lockout indicator.
- INTENTOS  output  2  current consecutive-failure count.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=REPOSO, INTENTOS=0, timer=0.
  - ABRIR_PUERTA=0, ALARMA=0, BLOQUEO=0.
  - Edge-detect history registers reset to 1, so an input already high at reset release is not an event.
  - Asserting reset mid-operation aborts any state immediately: the door closes and the alarm clears.
- Edge detection:
  - ev_ok = ACCESO_ACEPTADO & ~prev_ok; ev_den = ACCESO_DENEGADO & ~prev_den.
  - prev_* register the inputs every cycle.
- States (one-hot, 4 bits): REPOSO, ABIERTO, ALARMA_PUERTA, BLOQUEADO. All outputs are registered and updated with the state (Moore).
- REPOSO (all outputs 0):
  - ev_den: if INTENTOS+1 == MAX_INTENTOS, go to BLOQUEADO and hold INTENTOS at MAX_INTENTOS; otherwise INTENTOS+=1 and stay.
  - ev_ok (without ev_den): go to ABIERTO, INTENTOS=0, timer=T_APERTURA-1.
  - ev_ok and ev_den in the same cycle is an illegal input; ev_den wins (fail-safe).
- ABIERTO (ABRIR_PUERTA=1):
  - Timer decrements each cycle. When the timer is 0, go to REPOSO if PUERTA_CERRADA=1, else to ALARMA_PUERTA.
  - ABRIR_PUERTA is therefore high for exactly T_APERTURA cycles, starting the cycle after the edge where the event is sampled.
  - ev_ok / ev_den in this state are ignored.
- ALARMA_PUERTA (ALARMA=1, ABRIR_PUERTA=0):
  - Go to REPOSO on the first cycle PUERTA_CERRADA=1.
  - PIN events are ignored.
- BLOQUEADO (BLOQUEO=1, ALARMA=1):
  - All PIN events are ignored.
  - DESBLOQUEO_ADMIN=1 sends the block to REPOSO with INTENTOS=0.
  - DESBLOQUEO_ADMIN has no effect in any other state.
- INTENTOS saturates and never wraps. A successful access always clears it.

Decomposition:
- Shared package holds:
  - the 4-bit one-hot state constants (REPOSO=4'b0001, ABIERTO=4'b0010, ALARMA_PUERTA=4'b0100, BLOQUEADO=4'b1000);
  - default MAX_INTENTOS and T_APERTURA.
- Sub-module detector_flanco: 1-bit rising-edge detector with reset value 1 on its history register. Instantiated twice.
- Remaining logic (FSM, counter, timer) stays in control_puerta_acceso.

Test Plan:
- Reset release with ACCESO_ACEPTADO already high: no door open; all outputs 0, INTENTOS=0.
- One ACCESO_ACEPTADO rising edge, T_APERTURA=50, PUERTA_CERRADA=1: ABRIR_PUERTA high for exactly 50 cycles, then REPOSO with outputs 0.
- Three ACCESO_DENEGADO edges: INTENTOS goes 1,2,3 and BLOQUEO=ALARMA=1. A further ACCESO_ACEPTADO edge is ignored. DESBLOQUEO_ADMIN pulse leads to REPOSO with INTENTOS=0.
- Two denials, then an acceptance: INTENTOS 2 goes to 0 and the door opens. A subsequent denial gives INTENTOS=1 with no lockout.
- Open window expires with PUERTA_CERRADA=0: ALARMA=1 and ABRIR_PUERTA=0. Raising PUERTA_CERRADA gives ALARMA=0 next cycle.
- RESET_N pulled low mid-ABIERTO (cycle 20): ABRIR_PUERTA drops immediately without waiting for a clock edge. ACCESO_ACEPTADO and ACCESO_DENEGADO rising together in REPOSO count as a denial (INTENTOS+1, no open).
